// File: rtl/alu_muldiv_seq_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: funct3 codes,
// FSM state encoding, operation classes and the divide-by-zero quotient.
package alu_muldiv_seq_pkg;

  localparam logic [2:0] kSAIL_MICROARCHITECTURE_MULDIV_MUL    = 3'b000;
  localparam logic [2:0] kSAIL_MICROARCHITECTURE_MULDIV_MULH   = 3'b001;
  localparam logic [2:0] kSAIL_MICROARCHITECTURE_MULDIV_MULHSU = 3'b010;
  localparam logic [2:0] kSAIL_MICROARCHITECTURE_MULDIV_MULHU  = 3'b011;
  localparam logic [2:0] kSAIL_MICROARCHITECTURE_MULDIV_DIV    = 3'b100;
  localparam logic [2:0] kSAIL_MICROARCHITECTURE_MULDIV_DIVU   = 3'b101;
  localparam logic [2:0] kSAIL_MICROARCHITECTURE_MULDIV_REM    = 3'b110;
  localparam logic [2:0] kSAIL_MICROARCHITECTURE_MULDIV_REMU   = 3'b111;

  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

  typedef enum logic {
    CLS_MUL = 1'b0,
    CLS_DIV = 1'b1
  } op_class_e;

  // Divide-family ops all have funct3[2] set.
  function automatic op_class_e op_class(input logic [2:0] f3);
    return f3[2] ? CLS_DIV : CLS_MUL;
  endfunction

endpackage

// File: rtl/alu_muldiv_seq_step_unit.sv
// One radix-2 iteration of shift-add multiply or restoring divide.
// The single WIDTH+2-bit adder here is the only adder in the iteration path.
// For divide, the LSB of acc_o is left clear; the caller shifts in qbit_o.
module muldiv_step_unit
  import alu_muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  op_class_e              cls_i,
  input  logic [2*WIDTH-1:0]     acc_i,
  input  logic [WIDTH-1:0]       opnd_i,
  output logic [2*WIDTH-1:0]     acc_o,
  output logic                   qbit_o
);

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] add_x;
  logic [WIDTH+1:0] add_y;
  logic             add_cin;
  logic [WIDTH+1:0] sum;

  assign rem_sh = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};

  // Operand steering: add multiplicand to the upper half, or subtract divisor
  always_comb begin
    add_x   = '0;
    add_y   = '0;
    add_cin = 1'b0;
    if (cls_i == CLS_DIV) begin
      add_x   = {1'b0, rem_sh};
      add_y   = ~{2'b00, opnd_i};
      add_cin = 1'b1;
    end else begin
      add_x = {2'b00, acc_i[2*WIDTH-1:WIDTH]};
      add_y = acc_i[0] ? {2'b00, opnd_i} : '0;
    end
  end

  assign sum = add_x + add_y + {{(WIDTH+1){1'b0}}, add_cin};

  // Next accumulator: shift right for multiply, restore-or-keep for divide
  always_comb begin
    qbit_o = 1'b0;
    acc_o  = '0;
    if (cls_i == CLS_DIV) begin
      // A clear top bit means the trial difference is non-negative.
      qbit_o = ~sum[WIDTH+1];
      acc_o  = {(qbit_o ? sum[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                acc_i[WIDTH-2:0], 1'b0};
    end else begin
      acc_o = {sum[WIDTH:0], acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// RV32M multi-cycle sequencer. Holds the FSM, iteration counter, operand
// magnitudes, result sign and the registered result; each ITER cycle
// hands the accumulator to muldiv_step_unit.
module alu_muldiv_seq
  import alu_muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2:0]         op_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opnd_q;
  logic               neg_q;
  logic               special_q;
  logic [WIDTH-1:0]   result_q;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return ~v + (2*WIDTH)'(1);
  endfunction

  // Operands sit in acc_q as {a, b} between the accept and PREP.
  logic [WIDTH-1:0] a_w, b_w, mag_a, mag_b;
  logic             signed_a, signed_b, sgn_a, sgn_b;
  logic             is_div, div_zero, div_ovf, prep_neg;
  op_class_e        cls;

  assign a_w = acc_q[2*WIDTH-1:WIDTH];
  assign b_w = acc_q[WIDTH-1:0];
  assign cls = op_class(op_q);
  assign is_div = (cls == CLS_DIV);

  assign signed_a = (op_q == kSAIL_MICROARCHITECTURE_MULDIV_MULH)   ||
                    (op_q == kSAIL_MICROARCHITECTURE_MULDIV_MULHSU) ||
                    (op_q == kSAIL_MICROARCHITECTURE_MULDIV_DIV)    ||
                    (op_q == kSAIL_MICROARCHITECTURE_MULDIV_REM);
  assign signed_b = (op_q == kSAIL_MICROARCHITECTURE_MULDIV_MULH)   ||
                    (op_q == kSAIL_MICROARCHITECTURE_MULDIV_DIV)    ||
                    (op_q == kSAIL_MICROARCHITECTURE_MULDIV_REM);
  assign sgn_a = signed_a & a_w[WIDTH-1];
  assign sgn_b = signed_b & b_w[WIDTH-1];
  // The most negative value maps to 2**(WIDTH-1), which fits unsigned.
  assign mag_a = sgn_a ? neg_w(a_w) : a_w;
  assign mag_b = sgn_b ? neg_w(b_w) : b_w;

  assign div_zero = is_div && (b_w == '0);
  assign div_ovf  = is_div && !op_q[0] && (a_w == MIN_NEG) && (b_w == ALL_ONES);
  // Remainder follows the dividend sign; product and quotient use the xor.
  assign prep_neg = (is_div && op_q[1]) ? sgn_a : (sgn_a ^ sgn_b);

  logic [2*WIDTH-1:0] step_acc;
  logic               step_qbit;

  muldiv_step_unit #(.WIDTH(WIDTH)) u_step (
    .cls_i  (cls),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (step_acc),
    .qbit_o (step_qbit)
  );

  // Sign fix-up and result selection for the FIX state
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quot_s, rem_s, fix_res;

  assign prod_s = neg_q ? neg_2w(acc_q) : acc_q;
  assign quot_s = neg_q ? neg_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
  assign rem_s  = neg_q ? neg_w(acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    fix_res = '0;
    if (special_q) begin
      fix_res = acc_q[WIDTH-1:0];
    end else if (is_div) begin
      fix_res = op_q[1] ? rem_s : quot_s;
    end else if (op_q == kSAIL_MICROARCHITECTURE_MULDIV_MUL) begin
      fix_res = prod_s[WIDTH-1:0];
    end else begin
      fix_res = prod_s[2*WIDTH-1:WIDTH];
    end
  end

  // Sequencer FSM: reset beats flush, flush beats every handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      neg_q     <= 1'b0;
      special_q <= 1'b0;
      result_q  <= '0;
    end else if (flush) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q    <= op;
            acc_q   <= {a, b};
            state_q <= PREP;
          end
        end
        PREP: begin
          cnt_q     <= '0;
          neg_q     <= prep_neg;
          special_q <= div_zero | div_ovf;
          // Special results still pass through FIX so that every result
          // is committed to result_q from one place.
          if (div_zero) begin
            acc_q   <= {a_w, (op_q[1] ? a_w : ALL_ONES)};
            state_q <= FIX;
          end else if (div_ovf) begin
            acc_q   <= {a_w, (op_q[1] ? {WIDTH{1'b0}} : MIN_NEG)};
            state_q <= FIX;
          end else begin
            acc_q   <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
            opnd_q  <= is_div ? mag_b : mag_a;
            state_q <= ITER;
          end
        end
        ITER: begin
          acc_q <= {step_acc[2*WIDTH-1:1], (is_div ? step_qbit : step_acc[0])};
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          result_q <= fix_res;
          state_q  <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq: directed RV32M vectors, random
// operations against a 64-bit arithmetic reference, back-pressure, flush
// and mid-operation reset.
module tb_alu_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [2:0]  op;
  logic [31:0] a, b, result;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] MINV = 32'h80000000;
  localparam logic [31:0] ONES = 32'hFFFFFFFF;

  alu_muldiv_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .op(op), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: RV32M semantics computed with 64-bit integer arithmetic.
  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy;
    longint unsigned ux, uy, up;
    logic [63:0]     p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      3'd0: begin up = ux * uy; p = up; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * longint'(uy); return p[63:32]; end
      3'd3: begin up = ux * uy; p = up; return p[63:32]; end
      3'd4: begin
        if (y == 0) return ONES;
        if (x == MINV && y == ONES) return MINV;
        p = sx / sy; return p[31:0];
      end
      3'd5: begin
        if (y == 0) return ONES;
        up = ux / uy; p = up; return p[31:0];
      end
      3'd6: begin
        if (y == 0) return x;
        if (x == MINV && y == ONES) return 32'd0;
        p = sx % sy; return p[31:0];
      end
      default: begin
        if (y == 0) return x;
        up = ux % uy; p = up; return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o[2] && (y == 0 || (!o[0] && x == MINV && y == ONES))) return 2;
    return 34;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return ONES;
      2: return MINV;
      3: return $urandom_range(0, 20);
      4: return 32'd0 - $urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction

  // Issue one op, count cycles from the accept edge to out_valid, optionally ack.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit ack, output logic [31:0] r, output int lat);
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 3'($urandom); a = $urandom; b = $urandom;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    r = result;
    if (ack) begin
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s got in_ready=%b out_valid=%b result=%h busy=%b want 1 0 00000000 0",
               tag, in_ready, out_valid, result, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [2:0]  ops [12] = '{3'd3, 3'd0, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
    logic [31:0] xs  [12] = '{ONES, 32'hFFFFFFFD, 32'hFFFFFFFD, ONES, 32'hFFFFFFF9, 32'hFFFFFFF9,
                              MINV, MINV, 32'd5, 32'd5, MINV, MINV};
    logic [31:0] ys  [12] = '{ONES, 32'd7, 32'd7, 32'd2, 32'd2, 32'd2, 32'd3, 32'd3, 32'd0, 32'd0, ONES, ONES};
    logic [31:0] want[12] = '{32'hFFFFFFFE, 32'hFFFFFFEB, ONES, ONES, 32'hFFFFFFFD, ONES,
                              32'h2AAAAAAA, 32'd2, ONES, 32'd5, MINV, 32'd0};
    int          lats[12] = '{34, 34, 34, 34, 34, 34, 34, 34, 2, 2, 2, 2};
    logic [31:0] r;
    int          lat;
    for (int i = 0; i < 12; i++) begin
      run_op(ops[i], xs[i], ys[i], 1'b1, r, lat);
      checks++;
      if (r !== want[i]) begin
        failures++;
        $display("FAIL directed_result[%0d] op=%0d got=%h want=%h", i, ops[i], r, want[i]);
      end
      checks++;
      if (lat != lats[i]) begin
        failures++;
        $display("FAIL directed_latency[%0d] op=%0d got=%0d want=%0d", i, ops[i], lat, lats[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] x, y, r;
    int          lat;
    for (int i = 0; i < 48; i++) begin
      o = 3'($urandom_range(0, 7));
      x = pick_operand();
      y = pick_operand();
      run_op(o, x, y, 1'b1, r, lat);
      checks++;
      if (r !== ref_res(o, x, y) || lat != ref_lat(o, x, y)) begin
        failures++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h got=%h/%0d want=%h/%0d",
                 i, o, x, y, r, lat, ref_res(o, x, y), ref_lat(o, x, y));
      end
    end
  endtask

  task automatic test_back_pressure();
    logic [31:0] r;
    int          lat;
    run_op(3'd1, 32'h12345678, 32'h9ABCDEF0, 1'b0, r, lat);
    checks++;
    if (r !== ref_res(3'd1, 32'h12345678, 32'h9ABCDEF0) || lat != 34) begin
      failures++;
      $display("FAIL bp_result got=%h/%0d want=%h/34", r, lat, ref_res(3'd1, 32'h12345678, 32'h9ABCDEF0));
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1; op = 3'($urandom); a = $urandom; b = $urandom;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || result !== r || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d] got out_valid=%b result=%h in_ready=%b want 1 %h 0",
                 i, out_valid, result, in_ready, r);
      end
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_release got out_valid=%b in_ready=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
    end
  endtask

  // Abort at iteration 10 with flush (or reset), then confirm nothing emerges.
  task automatic test_abort(input bit use_reset);
    logic [31:0] r;
    int          lat;
    bit          seen;
    @(negedge clk);
    op = 3'd0; a = 32'd1234; b = 32'd5678; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    if (use_reset) rst_n = 1'b0; else flush = 1'b1;
    @(posedge clk); #1;
    if (use_reset) begin
      check_reset_outputs("abort_reset");
    end else begin
      checks++;
      if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
        failures++;
        $display("FAIL abort_flush got busy=%b in_ready=%b out_valid=%b want 0 1 0", busy, in_ready, out_valid);
      end
    end
    @(negedge clk); rst_n = 1'b1; flush = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL abort_no_output got out_valid=1 want 0 (reset=%0d)", use_reset);
    end
    run_op(3'd0, 32'd6, 32'd7, 1'b1, r, lat);
    checks++;
    if (r !== 32'd42 || lat != 34) begin
      failures++;
      $display("FAIL abort_then_mul got=%h/%0d want=0000002a/34", r, lat);
    end
  endtask

  task automatic test_flush_handshakes();
    logic [31:0] r, prev;
    int          lat;
    bit          seen;
    prev = result;
    @(negedge clk);
    op = 3'd0; a = 32'd3; b = 32'd3; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_at_accept got busy=%b in_ready=%b want 0 1", busy, in_ready);
    end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1 || result !== prev) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL flush_at_accept_dropped got out_valid/result activity want none");
    end
    run_op(3'd5, 32'd100, 32'd7, 1'b0, r, lat);
    @(negedge clk); flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1; flush = 1'b0; out_ready = 1'b0;
    checks++;
    if (r !== 32'd14 || out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_in_done got result=%h out_valid=%b busy=%b want 0000000e 0 0", r, out_valid, busy);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_pressure();
    test_abort(1'b0);
    test_abort(1'b1);
    test_flush_handshakes();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
